// File: rtl/mem_access_unit_if.sv
// Request/response channel between the execute stage and mem_access_unit.
// The execute stage holds the master modport; the access unit holds the slave modport.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: issues byte/half/word loads and stores to a word-wide data memory.
// Sub-word stores are done as read-modify-write because DM writes whole words only.
// Optional build macro BOUNDS_CHECK_EN: reject word indices >= DEPTH_WORDS at accept.
module mem_access_unit #(
   parameter int ADDR_W      = 16,
   parameter int DEPTH_WORDS = 32
) (
   input  logic              clk,
   input  logic              rst,
   mem_access_unit_if.slave  bus,
   output logic [ADDR_W-1:0] dm_address,
   output logic [31:0]       dm_wd,
   output logic              dm_we,
   input  logic [31:0]       dm_rd
);
   typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   state_t            state_reg, state_next;
   logic              we_reg;
   logic              uns_reg;
   logic [1:0]        size_reg;
   logic [ADDR_W+1:0] addr_reg;
   logic [15:0]       wdata_reg;
   logic [31:0]       dm_wd_reg;
   logic [31:0]       rdata_reg;
   logic              err_reg;

   logic              accept;
   logic              req_err;
   logic              oob;
   logic [7:0]        rd_lane [4];
   logic [7:0]        byte_val;
   logic [15:0]       half_val;
   logic [31:0]       load_val;
   logic [31:0]       merged_word;

   assign bus.req_ready = (state_reg == IDLE) & ~rst;
   assign accept        = bus.req_valid & bus.req_ready;

`ifdef BOUNDS_CHECK_EN
   assign oob = (bus.req_addr[31:2] >= 30'(DEPTH_WORDS));
`else
   // Without a range check the upper address bits and the depth are don't-cares.
   localparam int unused_depth = DEPTH_WORDS;
   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, bus.req_addr[31:ADDR_W+2]};
   assign oob = 1'b0;
`endif

   assign req_err = (bus.req_size == SZ_ILL)
                  | ((bus.req_size == SZ_HALF) & bus.req_addr[0])
                  | ((bus.req_size == SZ_WORD) & (bus.req_addr[1:0] != 2'b00))
                  | oob;

   // Per byte lane: split the read word and build the read-modify-write merge.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic hit;
      assign rd_lane[gi] = dm_rd[8*gi +: 8];
      assign hit = ((size_reg == SZ_BYTE) && (addr_reg[1:0] == LANE))
                || ((size_reg == SZ_HALF) && (addr_reg[1] == LANE[1]));
      assign merged_word[8*gi +: 8] = !hit ? rd_lane[gi]
                                    : ((size_reg == SZ_HALF) && LANE[0]) ? wdata_reg[15:8]
                                    : wdata_reg[7:0];
   end

   // Select the addressed lane of the loaded word and extend it.
   always_comb begin
      byte_val = rd_lane[addr_reg[1:0]];
      half_val = addr_reg[1] ? dm_rd[31:16] : dm_rd[15:0];
      case (size_reg)
         SZ_BYTE: load_val = {{24{~uns_reg & byte_val[7]}}, byte_val};
         SZ_HALF: load_val = {{16{~uns_reg & half_val[15]}}, half_val};
         default: load_val = dm_rd;
      endcase
   end

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Next-state decode; the access path is chosen once, at accept.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (req_err)                     state_next = RESP;
               else if (!bus.req_we)            state_next = LOAD;
               else if (bus.req_size == SZ_WORD) state_next = WRITE;
               else                             state_next = RMW_RD;
            end
         end
         LOAD:    state_next = RESP;
         RMW_RD:  state_next = WRITE;
         WRITE:   state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Latched request, merged write word and load result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_reg    <= 1'b0;
         uns_reg   <= 1'b0;
         size_reg  <= 2'b00;
         addr_reg  <= '0;
         wdata_reg <= '0;
         dm_wd_reg <= '0;
         rdata_reg <= '0;
         err_reg   <= 1'b0;
      end else if (accept) begin
         we_reg    <= bus.req_we;
         uns_reg   <= bus.req_unsigned;
         size_reg  <= bus.req_size;
         addr_reg  <= bus.req_addr[ADDR_W+1:0];
         wdata_reg <= bus.req_wdata[15:0];
         dm_wd_reg <= bus.req_wdata;
         rdata_reg <= '0;
         err_reg   <= req_err;
      end else begin
         case (state_reg)
            LOAD:    rdata_reg <= load_val;
            RMW_RD:  dm_wd_reg <= merged_word;
            default: ;
         endcase
      end
   end

   assign dm_address     = (state_reg != IDLE) ? addr_reg[ADDR_W+1:2] : '0;
   assign dm_we          = (state_reg == WRITE) & we_reg;
   assign dm_wd          = dm_wd_reg;
   assign bus.resp_valid = (state_reg == RESP);
   assign bus.resp_rdata = (state_reg == RESP) ? rdata_reg : 32'h0;
   assign bus.resp_err   = (state_reg == RESP) & err_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table driven through a
// scoreboard queue, plus hand sequences for reset aborts and held requests.
module tb_mem_access_unit;
   localparam int ADDR_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_clr = 1'b1;
   always #5 clk = ~clk;

   mem_access_unit_if bus();
   logic [ADDR_W-1:0] dm_address;
   logic [31:0]       dm_wd;
   logic              dm_we;
   logic [31:0]       dm_rd;

   mem_access_unit #(.ADDR_W(ADDR_W), .DEPTH_WORDS(32)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .dm_address(dm_address), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
   );

   // Data memory model: combinational read, synchronous whole-word write.
   logic [31:0] mem [0:63];
   assign dm_rd = mem[dm_address[5:0]];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      end else if (dm_we) begin
         mem[dm_address[5:0]] <= dm_wd;
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_we;
      int          idx;
      logic [31:0] exp_mem;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
      int          tag;
   } sb_t;

   sb_t  sb_q[$];
   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   we_cnt = 0;
   logic [ADDR_W-1:0] we_addr = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic err, input int lat,
                               input int nwe, input int idx, input logic [31:0] memv);
      vec_t v;
      v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat; v.exp_we = nwe;
      v.idx = idx; v.exp_mem = memv;
      return v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: count write pulses and check every response against the scoreboard.
   always @(negedge clk) begin
      sb_t e;
      if (dm_we) begin
         we_cnt++;
         we_addr = dm_address;
      end
      if (bus.resp_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("v%0d_rdata", e.tag), bus.resp_rdata, e.rdata);
            chk($sformatf("v%0d_err", e.tag), 32'(bus.resp_err), 32'(e.err));
            chk($sformatf("v%0d_latency", e.tag), 32'(cyc - e.acc + 1), 32'(e.lat));
            $display("resp tag=%0d rdata=0x%08h err=%0b lat=%0d", e.tag, bus.resp_rdata,
                     bus.resp_err, cyc - e.acc + 1);
         end
      end
   end

   task automatic drive(input vec_t v);
      bus.req_valid    = 1'b1;
      bus.req_we       = v.we;
      bus.req_size     = v.size;
      bus.req_unsigned = v.uns;
      bus.req_addr     = v.addr;
      bus.req_wdata    = v.wdata;
   endtask

   task automatic wait_drain(input int tag);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         #2;
         if (sb_q.size() == 0) break;
      end
      if (sb_q.size() != 0) begin
         chk($sformatf("v%0d_resp_timeout", tag), 32'(sb_q.size()), 32'd0);
         sb_q.delete();
      end
   endtask

   task automatic apply(input vec_t v, input int tag);
      sb_t e;
      int  base;
      bit  ready_seen;
      @(negedge clk);
      drive(v);
      ready_seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bus.req_ready) begin
            ready_seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ready_seen) begin
         chk($sformatf("v%0d_accept_timeout", tag), 32'd0, 32'd1);
         bus.req_valid = 1'b0;
         return;
      end
      base = we_cnt;
      @(posedge clk);
      #1;
      e.rdata = v.exp_rdata; e.err = v.exp_err; e.lat = v.exp_lat; e.acc = cyc; e.tag = tag;
      sb_q.push_back(e);
      bus.req_valid = 1'b0;
      wait_drain(tag);
      chk($sformatf("v%0d_we_pulses", tag), 32'(we_cnt - base), 32'(v.exp_we));
      if (v.exp_we != 0) chk($sformatf("v%0d_we_addr", tag), 32'(we_addr), 32'(v.idx));
      if (v.idx >= 0)    chk($sformatf("v%0d_mem", tag), mem[v.idx], v.exp_mem);
   endtask

   initial begin
      int   base;
      int   n_acc;
      int   acc_c [2];
      sb_t  e;
      vec_t v;

      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
      bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

      //            we    sz     u     addr    wdata         rdata         err  lat we idx mem
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 2, 32'hDEADBEEF));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, -1, 32'h0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h09, 32'h0,        32'hFFFFFFBE, 1'b0, 2, 0, -1, 32'h0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h09, 32'h0,        32'h000000BE, 1'b0, 2, 0, -1, 32'h0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h0A, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 0, -1, 32'h0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h08, 32'h0,        32'h0000BEEF, 1'b0, 2, 0, -1, 32'h0));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h0B, 32'h00000011, 32'h0,        1'b0, 3, 1, 2, 32'h11ADBEEF));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h08, 32'h00002233, 32'h0,        1'b0, 3, 1, 2, 32'h11AD2233));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h0B, 32'h0,        32'h00000011, 1'b0, 2, 0, -1, 32'h0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h08, 32'h0,        32'h00002233, 1'b0, 2, 0, -1, 32'h0));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 32'h04, 32'hFFFFFF80, 32'h0,        1'b0, 3, 1, 1, 32'h00000080));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h04, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0, -1, 32'h0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b1, 32'h06, 32'h0,        32'h00000000, 1'b0, 2, 0, -1, 32'h0));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 32'h0,        1'b0, 2, 1, 4, 32'h12345678));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h00001234, 1'b0, 2, 0, -1, 32'h0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        32'h00000034, 1'b0, 2, 0, -1, 32'h0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'h00005678, 1'b0, 2, 0, -1, 32'h0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        32'h0,        1'b1, 1, 0, 1, 32'h00000080));
      vecs.push_back(mk(1'b1, 2'b01, 1'b0, 32'h03, 32'h0000FFFF, 32'h0,        1'b1, 1, 0, 0, 32'h00000000));
      vecs.push_back(mk(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 4, 32'h12345678));
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h09, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 2, 32'h11AD2233));
`ifdef BOUNDS_CHECK_EN
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D, 32'h0,        1'b1, 1, 0, 32, 32'h0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        32'h0,        1'b1, 1, 0, -1, 32'h0));
`else
      vecs.push_back(mk(1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFEF00D, 32'h0,        1'b0, 2, 1, 32, 32'hCAFEF00D));
      vecs.push_back(mk(1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0, -1, 32'h0));
`endif

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("ready_in_reset", 32'(bus.req_ready), 32'd0);
      rst = 1'b0;
      mem_clr = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
      chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
      chk("rst_dm_we", 32'(dm_we), 32'd0);
      chk("rst_dm_wd", dm_wd, 32'h0);
      chk("rst_dm_address", 32'(dm_address), 32'd0);
      $display("reset state checked");

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], i);
         $display("vec %0d we=%0b size=%0d addr=0x%08h done", i, vecs[i].we, vecs[i].size,
                  vecs[i].addr);
      end

      // Reset while in RMW_RD: no write, no response, memory untouched.
      @(negedge clk);
      v = mk(1'b1, 2'b00, 1'b0, 32'h0B, 32'h00000055, 32'h0, 1'b0, 3, 0, 2, 32'h11AD2233);
      drive(v);
      base = we_cnt;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("rmw_abort_addr", 32'(dm_address), 32'd2);
      rst = 1'b1;
      #1;
      chk("rmw_abort_we", 32'(dm_we), 32'd0);
      chk("rmw_abort_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rmw_abort_mem", mem[2], 32'h11AD2233);
      chk("rmw_abort_pulses", 32'(we_cnt - base), 32'd0);
      chk("rmw_abort_ready_after", 32'(bus.req_ready), 32'd1);
      $display("reset during RMW_RD checked");

      // Reset while in WRITE: dm_we drops at once, word not written.
      @(negedge clk);
      v = mk(1'b1, 2'b10, 1'b0, 32'h14, 32'h5A5A5A5A, 32'h0, 1'b0, 2, 0, 5, 32'h0);
      drive(v);
      base = we_cnt;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("wr_abort_we_before", 32'(dm_we), 32'd1);
      rst = 1'b1;
      #1;
      chk("wr_abort_we_async", 32'(dm_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("wr_abort_mem", mem[5], 32'h0);
      chk("wr_abort_pulses", 32'(we_cnt - base), 32'd0);
      $display("reset during WRITE checked");

      // Request held high while busy: second accept on the edge after the RESP cycle.
      @(negedge clk);
      v = mk(1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h11AD2233, 1'b0, 2, 0, -1, 32'h0);
      drive(v);
      n_acc = 0;
      acc_c[0] = 0;
      acc_c[1] = 0;
      for (int k = 0; k < 12 && n_acc < 2; k++) begin
         if (bus.req_ready) begin
            @(posedge clk);
            #1;
            e.rdata = v.exp_rdata; e.err = 1'b0; e.lat = 2; e.acc = cyc; e.tag = 100 + n_acc;
            sb_q.push_back(e);
            acc_c[n_acc] = cyc;
            n_acc++;
            if (n_acc == 2) bus.req_valid = 1'b0;
         end
         @(negedge clk);
      end
      bus.req_valid = 1'b0;
      wait_drain(100);
      chk("hold_accepts", 32'(n_acc), 32'd2);
      chk("hold_accept_gap", 32'(acc_c[1] - acc_c[0]), 32'd3);
      $display("held request accepted %0d times, gap %0d edges", n_acc, acc_c[1] - acc_c[0]);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_vec);
      $fatal(1, "watchdog");
   end
endmodule
